// File: rtl/draw_bg.sv
// Background draw stage: maps screen counts to an upscaled image address,
// reads the background ROM and re-aligns the timing signals with rgb.
module draw_bg #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 12,
  parameter int IMG_W = 256,
  parameter int IMG_H = 192,
  parameter int SCALE_SHIFT = 2,
  parameter int X_OFF = 0,
  parameter int Y_OFF = 0,
  parameter logic [DATA_WIDTH-1:0] BORDER_COLOR = 12'h060
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [10:0]           hcount_in,
  input  logic [10:0]           vcount_in,
  input  logic                  hsync_in,
  input  logic                  hblnk_in,
  input  logic                  vsync_in,
  input  logic                  vblnk_in,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [10:0]           hcount_out,
  output logic [10:0]           vcount_out,
  output logic                  hsync_out,
  output logic                  hblnk_out,
  output logic                  vsync_out,
  output logic                  vblnk_out,
  output logic [DATA_WIDTH-1:0] rgb_out
);

  if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_WIDTH)) begin : g_chk
    $error("draw_bg: IMG_W*IMG_H does not fit in ADDR_WIDTH");
  end

  logic signed [11:0] x_rel;
  logic signed [11:0] y_rel;
  logic signed [11:0] x_img;
  logic signed [11:0] y_img;
  logic               in_img;

  assign x_rel = $signed({1'b0, hcount_in}) - $signed(12'(X_OFF));
  assign y_rel = $signed({1'b0, vcount_in}) - $signed(12'(Y_OFF));
  assign x_img = x_rel >>> SCALE_SHIFT;
  assign y_img = y_rel >>> SCALE_SHIFT;

  assign in_img = !x_rel[11] && !y_rel[11]
               && (32'(x_img) < 32'(IMG_W))
               && (32'(y_img) < 32'(IMG_H));

  // Timing bundle: {hcount, vcount, hsync, hblnk, vsync, vblnk}
  logic [25:0] t_in;
  logic [25:0] t1;
  logic [25:0] t2;
  logic [25:0] t3;
  logic        img1;
  logic        img2;
  logic        rst_q;

  assign t_in = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      img1     <= 1'b0;
      img2     <= 1'b0;
      t1       <= '0;
      t2       <= '0;
      t3       <= '0;
      rgb_out  <= '0;
      rst_q    <= 1'b1;
    end else begin
      rom_addr <= in_img ? ADDR_WIDTH'(y_img * IMG_W + x_img) : '0;
      img1     <= in_img;
      img2     <= img1;
      t1       <= t_in;
      t2       <= t1;
      t3       <= t2;
      rst_q    <= 1'b0;
      if (t2[2] || t2[0])
        rgb_out <= '0;
      else if (img2)
        rgb_out <= rom_data;
      else
        rgb_out <= BORDER_COLOR;
    end
  end

  // ROM stays idle through reset and the first cycle after release.
  assign rom_en = !(rst || rst_q);

  assign hcount_out = t3[25:15];
  assign vcount_out = t3[14:4];
  assign hsync_out  = t3[3];
  assign hblnk_out  = t3[2];
  assign vsync_out  = t3[1];
  assign vblnk_out  = t3[0];

endmodule
